// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 slave memory with independent read and write burst engines over one word array.
//   clk, rst (async, active-low)
//   AW/W/B: s_axi_aw*, s_axi_w*, s_axi_b*   write address, data (byte strobes), response
//   AR/R:   s_axi_ar*, s_axi_r*             read address, data/resp/last
//   Optional: define AXI_MEM_BACKPRESSURE_EN to gate readies/rvalid with a 16-bit LFSR.
module axi4_slave_mem #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] FILL       = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int TOP   = DEPTH_LOG2 + OFF;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(NB);
    localparam logic [DATA_W-1:0] FILL_W = {(DATA_W/32){FILL}};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL_W};

    function automatic logic [DEPTH_LOG2-1:0] idx(input logic [ADDR_W-1:0] a);
        return DEPTH_LOG2'(a >> OFF);
    endfunction

    function automatic logic oob(input logic [ADDR_W-1:0] a);
        return |(a >> TOP);
    endfunction

    logic rdy_gate, rv_gate;
`ifdef AXI_MEM_BACKPRESSURE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign rdy_gate = lfsr[0];
    assign rv_gate  = lfsr[1];
`else
    assign rdy_gate = 1'b1;
    assign rv_gate  = 1'b1;
`endif

    // Keeps all readies low for the first cycle after reset release
    logic up;

    w_state_t          w_state, w_next;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wlen, wcnt;
    logic [1:0]        wburst;
    logic              werr, aw_hs, w_hs, w_end;

    always_comb begin
        s_axi_awready = up && w_state == W_IDLE && rdy_gate;
        s_axi_wready  = w_state == W_DATA && rdy_gate;
        s_axi_bvalid  = w_state == W_RESP;
        s_axi_bresp   = (s_axi_bvalid && (werr || wburst == 2'd3)) ? 2'd2 : 2'd0;
        aw_hs         = s_axi_awvalid && s_axi_awready;
        w_hs          = s_axi_wvalid && s_axi_wready;
        w_end         = wcnt == wlen;
        w_next        = aw_hs ? W_DATA :
                        (w_hs && w_end) ? W_RESP :
                        (s_axi_bvalid && s_axi_bready) ? W_IDLE : w_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up      <= 1'b0;
            w_state <= W_IDLE;
            waddr   <= '0;
            wlen    <= '0;
            wcnt    <= '0;
            wburst  <= '0;
            werr    <= 1'b0;
        end else begin
            up      <= 1'b1;
            w_state <= w_next;
            if (aw_hs) begin
                waddr  <= s_axi_awaddr;
                wlen   <= s_axi_awlen;
                wburst <= s_axi_awburst;
                wcnt   <= '0;
                werr   <= 1'b0;
            end else if (w_hs) begin
                waddr <= (wburst == 2'd0) ? waddr : waddr + STEP;
                wcnt  <= wcnt + 8'd1;
                // wlast must coincide exactly with the beat counter reaching len
                werr  <= werr | oob(waddr) | (s_axi_wlast != w_end);
            end
        end
    end

    // Out-of-range beats are dropped rather than aliased onto the array
    always_ff @(posedge clk)
        if (w_hs && !oob(waddr))
            for (int b = 0; b < NB; b++)
                if (s_axi_wstrb[b]) mem[idx(waddr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];

    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] raddr, r_nxt, rd_addr;
    logic [7:0]        rlen, rcnt;
    logic [1:0]        rburst;
    logic              rhold, ar_hs, r_hs, r_load;
    logic [DATA_W-1:0] rd_val;

    always_comb begin
        s_axi_arready = up && r_state == R_IDLE && rdy_gate;
        // Once shown, rvalid is held until accepted so the beat cannot be withdrawn
        s_axi_rvalid  = r_state == R_DATA && (rhold || rv_gate);
        s_axi_rlast   = s_axi_rvalid && rcnt == rlen;
        ar_hs         = s_axi_arvalid && s_axi_arready;
        r_hs          = s_axi_rvalid && s_axi_rready;
        r_load        = ar_hs || (r_hs && !s_axi_rlast);
        r_nxt         = (rburst == 2'd0) ? raddr : raddr + STEP;
        rd_addr       = ar_hs ? s_axi_araddr : r_nxt;
        rd_val        = oob(rd_addr) ? FILL_W : mem[idx(rd_addr)];
        r_next        = ar_hs ? R_DATA : (r_hs && s_axi_rlast) ? R_IDLE : r_state;
    end

    // Next beat is fetched at the handshake edge, so a same-cycle write is seen only by later beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= R_IDLE;
            raddr       <= '0;
            rlen        <= '0;
            rcnt        <= '0;
            rburst      <= '0;
            rhold       <= 1'b0;
            s_axi_rdata <= '0;
            s_axi_rresp <= '0;
        end else begin
            r_state <= r_next;
            rhold   <= s_axi_rvalid && !s_axi_rready;
            if (ar_hs) begin
                raddr  <= s_axi_araddr;
                rlen   <= s_axi_arlen;
                rburst <= s_axi_arburst;
                rcnt   <= '0;
            end else if (r_load) begin
                raddr <= r_nxt;
                rcnt  <= rcnt + 8'd1;
            end
            if (r_load) begin
                s_axi_rdata <= rd_val;
                // SLVERR sticks for the rest of the burst once any beat falls outside the array
                s_axi_rresp <= {oob(rd_addr) || (!ar_hs && s_axi_rresp[1]), 1'b0};
            end
        end
    end
endmodule
